// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline-register slice.
//   - DATA_W / ADDR_W defaults for the data and register-address fields
//   - regfile write-data source codes (rf_mux_sel)
//   - HI/LO write-data source codes (hi_mux_sel / lo_mux_sel)
//   - architectural zero register index
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_ADDR_W = 5;

    // Regfile write-data source select
    typedef enum logic [2:0] {
        RF_SEL_LO     = 3'd0,
        RF_SEL_PC4    = 3'd1,
        RF_SEL_CLZ    = 3'd2,
        RF_SEL_CP0    = 3'd3,
        RF_SEL_DMEM   = 3'd4,
        RF_SEL_ALU    = 3'd5,
        RF_SEL_HI     = 3'd6,
        RF_SEL_MUL_LO = 3'd7
    } rf_sel_e;

    // HI / LO write-data source select
    typedef enum logic [1:0] {
        HL_SEL_DIV  = 2'd0,
        HL_SEL_MUL  = 2'd1,
        HL_SEL_RS   = 2'd2,
        HL_SEL_ZERO = 2'd3
    } hilo_sel_e;

    localparam logic [PIPE_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_dff.sv
// pipe_dff: width-parameterised pipeline register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q
//   en    : load enable (hold when low)
//   clr   : synchronous clear, overrides en
//   d     : next value
//   q     : registered value
module pipe_dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_mem_wb_reg.sv
// pipe_mem_wb_reg: MEM/WB pipeline register of the MIPS pipeline.
// Captures MEM-stage results, destination, enables and mux selects and
// presents them to write-back one cycle later. Priority per edge:
// flush > stall > load. Write enables are sanitised so bubbles and writes
// to $0 never reach architectural state.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall, flush        : hazard-unit hold / bubble insertion
//   mem_valid           : MEM slot holds a real instruction
//   mem_<data> (x12)    : DATA_W-bit results/operands
//   mem_rf_waddr        : destination register
//   mem_*_wena          : regfile / HI / LO write enables
//   mem_*_mux_sel       : write-back source selects
//   wb_*                : registered copies, wb_valid
//   retire_cnt          : retired-instruction counter, present only when
//                         PIPE_MEM_WB_RETIRE_CNT_EN is defined, else 0
module pipe_mem_wb_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned ADDR_W = PIPE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_mul_hi,
    input  logic [DATA_W-1:0] mem_mul_lo,
    input  logic [DATA_W-1:0] mem_div_r,
    input  logic [DATA_W-1:0] mem_div_q,
    input  logic [DATA_W-1:0] mem_clz_out,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic [DATA_W-1:0] mem_dmem_out,
    input  logic [DATA_W-1:0] mem_pc4,
    input  logic [DATA_W-1:0] mem_rs_data_out,
    input  logic [DATA_W-1:0] mem_cp0_out,
    input  logic [DATA_W-1:0] mem_hi_out,
    input  logic [DATA_W-1:0] mem_lo_out,
    input  logic [ADDR_W-1:0] mem_rf_waddr,
    input  logic              mem_rf_wena,
    input  logic              mem_hi_wena,
    input  logic              mem_lo_wena,
    input  logic [1:0]        mem_hi_mux_sel,
    input  logic [1:0]        mem_lo_mux_sel,
    input  logic [2:0]        mem_rf_mux_sel,
    output logic [DATA_W-1:0] wb_mul_hi,
    output logic [DATA_W-1:0] wb_mul_lo,
    output logic [DATA_W-1:0] wb_div_r,
    output logic [DATA_W-1:0] wb_div_q,
    output logic [DATA_W-1:0] wb_clz_out,
    output logic [DATA_W-1:0] wb_alu_out,
    output logic [DATA_W-1:0] wb_dmem_out,
    output logic [DATA_W-1:0] wb_pc4,
    output logic [DATA_W-1:0] wb_rs_data_out,
    output logic [DATA_W-1:0] wb_cp0_out,
    output logic [DATA_W-1:0] wb_hi_out,
    output logic [DATA_W-1:0] wb_lo_out,
    output logic [ADDR_W-1:0] wb_rf_waddr,
    output logic              wb_rf_wena,
    output logic              wb_hi_wena,
    output logic              wb_lo_wena,
    output logic [1:0]        wb_hi_mux_sel,
    output logic [1:0]        wb_lo_mux_sel,
    output logic [2:0]        wb_rf_mux_sel,
    output logic              wb_valid,
    output logic [31:0]       retire_cnt
);

    localparam int unsigned DATA_GRP_W = 12 * DATA_W;
    localparam int unsigned CTRL_GRP_W = ADDR_W + 7;
    localparam int unsigned FLAG_GRP_W = 4;

    logic                  w_load_en;
    logic                  w_rf_wena;
    logic                  w_hi_wena;
    logic                  w_lo_wena;
    logic [DATA_GRP_W-1:0] w_data_d;
    logic [DATA_GRP_W-1:0] w_data_q;
    logic [CTRL_GRP_W-1:0] w_ctrl_d;
    logic [CTRL_GRP_W-1:0] w_ctrl_q;
    logic [FLAG_GRP_W-1:0] w_flag_d;
    logic [FLAG_GRP_W-1:0] w_flag_q;

    assign w_load_en = !stall;

    // Bubbles and $0 destinations never carry a live write enable.
    assign w_rf_wena = mem_rf_wena & mem_valid & (mem_rf_waddr != REG_ZERO);
    assign w_hi_wena = mem_hi_wena & mem_valid;
    assign w_lo_wena = mem_lo_wena & mem_valid;

    assign w_data_d = {mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q,
                       mem_clz_out, mem_alu_out, mem_dmem_out, mem_pc4,
                       mem_rs_data_out, mem_cp0_out, mem_hi_out, mem_lo_out};
    assign w_ctrl_d = {mem_rf_waddr, mem_hi_mux_sel, mem_lo_mux_sel, mem_rf_mux_sel};
    assign w_flag_d = {mem_valid, w_rf_wena, w_hi_wena, w_lo_wena};

    // flush is the synchronous clear inside pipe_dff, so it beats stall.
    pipe_dff #(.W(DATA_GRP_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_load_en),
        .clr   (flush),
        .d     (w_data_d),
        .q     (w_data_q)
    );

    pipe_dff #(.W(CTRL_GRP_W)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_load_en),
        .clr   (flush),
        .d     (w_ctrl_d),
        .q     (w_ctrl_q)
    );

    pipe_dff #(.W(FLAG_GRP_W)) u_flag (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_load_en),
        .clr   (flush),
        .d     (w_flag_d),
        .q     (w_flag_q)
    );

    assign {wb_mul_hi, wb_mul_lo, wb_div_r, wb_div_q,
            wb_clz_out, wb_alu_out, wb_dmem_out, wb_pc4,
            wb_rs_data_out, wb_cp0_out, wb_hi_out, wb_lo_out} = w_data_q;
    assign {wb_rf_waddr, wb_hi_mux_sel, wb_lo_mux_sel, wb_rf_mux_sel} = w_ctrl_q;
    assign {wb_valid, wb_rf_wena, wb_hi_wena, wb_lo_wena} = w_flag_q;

`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (mem_valid && !stall && !flush) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_mem_wb_reg.sv
module tb_pipe_mem_wb_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, mem_valid;
    logic [31:0] mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q, mem_clz_out, mem_alu_out;
    logic [31:0] mem_dmem_out, mem_pc4, mem_rs_data_out, mem_cp0_out, mem_hi_out, mem_lo_out;
    logic [4:0]  mem_rf_waddr;
    logic        mem_rf_wena, mem_hi_wena, mem_lo_wena;
    logic [1:0]  mem_hi_mux_sel, mem_lo_mux_sel;
    logic [2:0]  mem_rf_mux_sel;
    logic [31:0] wb_mul_hi, wb_mul_lo, wb_div_r, wb_div_q, wb_clz_out, wb_alu_out;
    logic [31:0] wb_dmem_out, wb_pc4, wb_rs_data_out, wb_cp0_out, wb_hi_out, wb_lo_out;
    logic [4:0]  wb_rf_waddr;
    logic        wb_rf_wena, wb_hi_wena, wb_lo_wena, wb_valid;
    logic [1:0]  wb_hi_mux_sel, wb_lo_mux_sel;
    logic [2:0]  wb_rf_mux_sel;
    logic [31:0] retire_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pipe_mem_wb_reg #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_mul_hi(mem_mul_hi), .mem_mul_lo(mem_mul_lo), .mem_div_r(mem_div_r),
        .mem_div_q(mem_div_q), .mem_clz_out(mem_clz_out), .mem_alu_out(mem_alu_out),
        .mem_dmem_out(mem_dmem_out), .mem_pc4(mem_pc4), .mem_rs_data_out(mem_rs_data_out),
        .mem_cp0_out(mem_cp0_out), .mem_hi_out(mem_hi_out), .mem_lo_out(mem_lo_out),
        .mem_rf_waddr(mem_rf_waddr), .mem_rf_wena(mem_rf_wena), .mem_hi_wena(mem_hi_wena),
        .mem_lo_wena(mem_lo_wena), .mem_hi_mux_sel(mem_hi_mux_sel),
        .mem_lo_mux_sel(mem_lo_mux_sel), .mem_rf_mux_sel(mem_rf_mux_sel),
        .wb_mul_hi(wb_mul_hi), .wb_mul_lo(wb_mul_lo), .wb_div_r(wb_div_r),
        .wb_div_q(wb_div_q), .wb_clz_out(wb_clz_out), .wb_alu_out(wb_alu_out),
        .wb_dmem_out(wb_dmem_out), .wb_pc4(wb_pc4), .wb_rs_data_out(wb_rs_data_out),
        .wb_cp0_out(wb_cp0_out), .wb_hi_out(wb_hi_out), .wb_lo_out(wb_lo_out),
        .wb_rf_waddr(wb_rf_waddr), .wb_rf_wena(wb_rf_wena), .wb_hi_wena(wb_hi_wena),
        .wb_lo_wena(wb_lo_wena), .wb_hi_mux_sel(wb_hi_mux_sel),
        .wb_lo_mux_sel(wb_lo_mux_sel), .wb_rf_mux_sel(wb_rf_mux_sel),
        .wb_valid(wb_valid), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive every mem_* field from one pattern, truncating for narrow fields.
    task automatic set_mem(input logic [31:0] v);
        mem_mul_hi = v; mem_mul_lo = v; mem_div_r = v; mem_div_q = v;
        mem_clz_out = v; mem_alu_out = v; mem_dmem_out = v; mem_pc4 = v;
        mem_rs_data_out = v; mem_cp0_out = v; mem_hi_out = v; mem_lo_out = v;
        mem_rf_waddr = v[4:0];
        mem_rf_wena = v[0]; mem_hi_wena = v[0]; mem_lo_wena = v[0];
        mem_hi_mux_sel = v[1:0]; mem_lo_mux_sel = v[1:0]; mem_rf_mux_sel = v[2:0];
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with clock running and garbage on inputs
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_valid = 1'b1;
        set_mem(32'hA5A5_A5A5);
        step(); step(); step();
        chk("rst_alu",    wb_alu_out, 32'h0);
        chk("rst_mul_hi", wb_mul_hi, 32'h0);
        chk("rst_lo_out", wb_lo_out, 32'h0);
        chk("rst_waddr",  {27'd0, wb_rf_waddr}, 32'h0);
        chk("rst_flags",  {28'd0, wb_valid, wb_rf_wena, wb_hi_wena, wb_lo_wena}, 32'h0);
        chk("rst_sels",   {25'd0, wb_hi_mux_sel, wb_lo_mux_sel, wb_rf_mux_sel}, 32'h0);
        chk("rst_cnt",    retire_cnt, 32'h0);

        // Pass-through
        #2 rst_n = 1'b1;
        set_mem(32'h0);
        mem_alu_out = 32'h1234_5678; mem_pc4 = 32'h0040_0004;
        mem_rf_waddr = 5'd8; mem_rf_wena = 1'b1; mem_valid = 1'b1; mem_rf_mux_sel = 3'd5;
        mem_hi_wena = 1'b1; mem_hi_mux_sel = 2'd2;
        chk("no_comb_path", wb_alu_out, 32'h0);
        step();
        chk("pt_alu",     wb_alu_out, 32'h1234_5678);
        chk("pt_pc4",     wb_pc4, 32'h0040_0004);
        chk("pt_waddr",   {27'd0, wb_rf_waddr}, 32'd8);
        chk("pt_rf_wena", {31'd0, wb_rf_wena}, 32'd1);
        chk("pt_rf_sel",  {29'd0, wb_rf_mux_sel}, 32'd5);
        chk("pt_valid",   {31'd0, wb_valid}, 32'd1);
        chk("pt_hi_wena", {31'd0, wb_hi_wena}, 32'd1);
        chk("pt_hi_sel",  {30'd0, wb_hi_mux_sel}, 32'd2);

        // Write to $0 is suppressed
        mem_rf_waddr = 5'd0; mem_rf_wena = 1'b1;
        step();
        chk("r0_wena",  {31'd0, wb_rf_wena}, 32'd0);
        chk("r0_valid", {31'd0, wb_valid}, 32'd1);

        // Bubble: data captured, enables forced off
        mem_valid = 1'b0; mem_rf_waddr = 5'd9; mem_hi_wena = 1'b1; mem_lo_wena = 1'b1;
        mem_alu_out = 32'hDEAD_BEEF;
        step();
        chk("bub_hi_wena", {31'd0, wb_hi_wena}, 32'd0);
        chk("bub_lo_wena", {31'd0, wb_lo_wena}, 32'd0);
        chk("bub_rf_wena", {31'd0, wb_rf_wena}, 32'd0);
        chk("bub_valid",   {31'd0, wb_valid}, 32'd0);
        chk("bub_alu",     wb_alu_out, 32'hDEAD_BEEF);

        // Stall holds X while inputs move to Y
        mem_valid = 1'b1; mem_alu_out = 32'h1111_1111; mem_rf_waddr = 5'd3;
        mem_rf_wena = 1'b1; mem_lo_wena = 1'b1;
        step();
        chk("x_alu", wb_alu_out, 32'h1111_1111);
        stall = 1'b1; mem_alu_out = 32'h2222_2222; mem_rf_waddr = 5'd4; mem_lo_wena = 1'b0;
        step(); chk("stall1_alu", wb_alu_out, 32'h1111_1111);
        step(); chk("stall2_alu", wb_alu_out, 32'h1111_1111);
        step(); chk("stall3_alu", wb_alu_out, 32'h1111_1111);
        chk("stall3_waddr",   {27'd0, wb_rf_waddr}, 32'd3);
        chk("stall3_lo_wena", {31'd0, wb_lo_wena}, 32'd1);
        chk("stall3_cnt_hold", retire_cnt,
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
            32'd3
`else
            32'd0
`endif
        );
        stall = 1'b0;
        step();
        chk("y_alu",     wb_alu_out, 32'h2222_2222);
        chk("y_waddr",   {27'd0, wb_rf_waddr}, 32'd4);
        chk("y_lo_wena", {31'd0, wb_lo_wena}, 32'd0);

        // stall + flush together behaves as flush
        stall = 1'b1; flush = 1'b1;
        step();
        chk("fl_valid", {31'd0, wb_valid}, 32'd0);
        chk("fl_flags", {28'd0, wb_valid, wb_rf_wena, wb_hi_wena, wb_lo_wena}, 32'h0);
        chk("fl_alu",   wb_alu_out, 32'h0);
        chk("fl_pc4",   wb_pc4, 32'h0);
        chk("fl_waddr", {27'd0, wb_rf_waddr}, 32'h0);
        chk("fl_sels",  {25'd0, wb_hi_mux_sel, wb_lo_mux_sel, wb_rf_mux_sel}, 32'h0);

        // Async reset mid-stall: stall forgotten, next edge loads
        flush = 1'b0; stall = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_rst_cnt", retire_cnt, 32'd0);
        #2 rst_n = 1'b1; stall = 1'b0;
        set_mem(32'h0); mem_valid = 1'b1; mem_cp0_out = 32'h0BAD_F00D;
        mem_rf_waddr = 5'd31; mem_rf_wena = 1'b1;
        step();
        chk("post_rst_cp0",  wb_cp0_out, 32'h0BAD_F00D);
        chk("post_rst_wena", {31'd0, wb_rf_wena}, 32'd1);

        // Counter: 5 valid loads (1 above + 4), 2 stalls, 1 flush, 1 bubble
        step(); step(); step(); step();
        stall = 1'b1; step(); step();
        stall = 1'b0; flush = 1'b1; step();
        flush = 1'b0; mem_valid = 1'b0; step();
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
        chk("cnt_five", retire_cnt, 32'd5);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_retire_cnt;
        chk("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
        mem_valid = 1'b1;
        step();
        chk("cnt_wrap", retire_cnt, 32'd0);
`else
        chk("cnt_off", retire_cnt, 32'd0);
        mem_valid = 1'b1;
        step();
        chk("cnt_off_after_load", retire_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
